// File: rtl/ob_unpack.sv
// ---------------------------------------------------------------------------
// ob_unpack
//
// Drains 32-bit words from the DDR output-buffer FIFO and delivers them to
// the compute engine as a counted stream of 16-bit elements (low half first,
// then high half). A transfer is armed with a one-cycle start pulse carrying
// the element count; completion is flagged with a one-cycle done pulse.
//
// Ports
//   clk_i          system clock, all logic on the rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        one-cycle start pulse, only honoured while idle
//   len_i          number of 16-bit elements to deliver (sampled with start)
//   busy_o         high whenever the block is not idle
//   done_o         one-cycle pulse at the end of a transfer
//   ob_re_o        one-cycle read-enable pulse to the output-buffer FIFO
//   ob_rd_data_i   FIFO read data
//   ob_rd_valid_i  FIFO read data valid
//   ob_empty_i     FIFO empty flag
//   m_data_o       element to the compute engine
//   m_valid_o      element valid
//   m_ready_i      compute engine accepts the element
//   dbg_state_o    current FSM state (observation only)
//   dbg_hold_o     current word hold register (observation only)
//   dbg_rem_o      elements still owed in this transfer (observation only)
//
// Stream handshake: an element moves on every rising edge where
// m_valid_o && m_ready_i. Once m_valid_o is raised, m_valid_o and m_data_o
// stay unchanged until that handshake happens; m_valid_o never depends
// combinationally on m_ready_i.
//
// FIFO side: exactly one read may be outstanding. A read is issued from
// FETCH only when the FIFO is non-empty, and the block then sits in WAIT
// until ob_rd_valid_i returns the word, so any read latency is tolerated.
// ---------------------------------------------------------------------------
module ob_unpack #(
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             ob_re_o,
    input  logic [31:0]      ob_rd_data_i,
    input  logic             ob_rd_valid_i,
    input  logic             ob_empty_i,
    output logic [15:0]      m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [2:0]       dbg_state_o,
    output logic [31:0]      dbg_hold_o,
    output logic [LEN_W-1:0] dbg_rem_o
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_EMIT_LO = 3'd3;
    localparam logic [2:0] ST_EMIT_HI = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [LEN_W-1:0] LEN_ZERO = '0;
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [2:0]       state_q,   state_d;
    logic [LEN_W-1:0] rem_q,     rem_d;
    logic [31:0]      hold_q,    hold_d;
    logic [15:0]      m_data_q,  m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             ob_re_q,   ob_re_d;
    logic             done_q,    done_d;
    logic             busy_q,    busy_d;

    logic             handshake;
    logic             last_elem;

    assign handshake = m_valid_q && m_ready_i;
    // The element being handed over now is the final one owed.
    assign last_elem = (rem_q == LEN_ONE);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        hold_d    = hold_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        ob_re_d   = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i == LEN_ZERO) begin
                        // Nothing to move: report completion straight away
                        // without touching the FIFO.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d   = len_i;
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_FETCH: begin
                // No timeout: an empty FIFO stalls here for as long as it
                // takes for the DMA side to deliver a word.
                if (!ob_empty_i) begin
                    ob_re_d = 1'b1;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (ob_rd_valid_i) begin
                    hold_d    = ob_rd_data_i;
                    m_data_d  = ob_rd_data_i[15:0];
                    m_valid_d = 1'b1;
                    state_d   = ST_EMIT_LO;
                end
            end

            ST_EMIT_LO: begin
                if (handshake) begin
                    rem_d = rem_q - LEN_ONE;
                    if (last_elem) begin
                        // Odd length: the high half of this word is dropped.
                        m_valid_d = 1'b0;
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                    end else begin
                        m_data_d = hold_q[31:16];
                        state_d  = ST_EMIT_HI;
                    end
                end
            end

            ST_EMIT_HI: begin
                if (handshake) begin
                    rem_d     = rem_q - LEN_ONE;
                    m_valid_d = 1'b0;
                    if (last_elem) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_DONE: begin
                // done_q was raised on entry, so it drops as we leave.
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                m_valid_d = 1'b0;
            end
        endcase

        // busy is registered from the next state so it is exact on the
        // same cycle as the state it describes.
        busy_d = (state_d != ST_IDLE);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            hold_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            ob_re_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            hold_q    <= hold_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            ob_re_q   <= ob_re_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all straight from registers)
    // -----------------------------------------------------------------------
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign ob_re_o     = ob_re_q;
    assign m_data_o    = m_data_q;
    assign m_valid_o   = m_valid_q;
    assign dbg_state_o = state_q;
    assign dbg_hold_o  = hold_q;
    assign dbg_rem_o   = rem_q;

endmodule

// File: tb/tb_ob_unpack.sv
// ---------------------------------------------------------------------------
// tb_ob_unpack
//
// Directed bench for ob_unpack. A small queue-based FIFO model with a
// one-cycle read latency feeds the DUT; a negedge monitor records handshaked
// elements and event cycles; each test task compares those against
// hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_ob_unpack;

    localparam int LEN_W = 16;
    localparam logic [2:0] ST_EMIT_HI = 3'd4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy, done, ob_re;
    logic [31:0]      ob_rd_data;
    logic             ob_rd_valid;
    logic             ob_empty;
    logic [15:0]      m_data;
    logic             m_valid;
    logic             m_ready;
    logic [2:0]       dbg_state;
    logic [31:0]      dbg_hold;
    logic [LEN_W-1:0] dbg_rem;

    ob_unpack #(.LEN_W(LEN_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .len_i        (len),
        .busy_o       (busy),
        .done_o       (done),
        .ob_re_o      (ob_re),
        .ob_rd_data_i (ob_rd_data),
        .ob_rd_valid_i(ob_rd_valid),
        .ob_empty_i   (ob_empty),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .dbg_state_o  (dbg_state),
        .dbg_hold_o   (dbg_hold),
        .dbg_rem_o    (dbg_rem)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- FIFO model ----------------
    logic [31:0] fifo_q[$];
    logic        fifo_empty = 1'b1;

    initial begin
        ob_rd_valid = 1'b0;
        ob_rd_data  = '0;
    end

    always @(posedge clk) begin
        ob_rd_valid <= 1'b0;
        if (ob_re && fifo_q.size() > 0) begin
            ob_rd_data  <= fifo_q.pop_front();
            ob_rd_valid <= 1'b1;
        end
    end

    always @(negedge clk) fifo_empty <= (fifo_q.size() == 0);
    assign ob_empty = fifo_empty;

    // ---------------- monitor ----------------
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    int re_cnt, done_cnt, done_cyc, last_hs, first_valid, first_re;
    int first_busy, last_busy;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                last_hs <= cyc;
            end
            if (m_valid && first_valid < 0) first_valid <= cyc;
            if (ob_re) begin
                re_cnt <= re_cnt + 1;
                if (first_re < 0) first_re <= cyc;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (busy) begin
                if (first_busy < 0) first_busy <= cyc;
                last_busy <= cyc;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int s_cyc;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        re_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs = -1;
        first_valid = -1; first_re = -1; first_busy = -1; last_busy = -1;
    endtask

    task automatic do_start(input logic [LEN_W-1:0] l);
        step();
        start = 1'b1;
        len   = l;
        s_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    // Bounded wait for the done pulse, then let busy settle.
    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        n_tests++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL wait_done: no done within %0d cycles (busy=%0b state=%0d)", budget, busy, dbg_state);
        end
        repeat (3) step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = '0; m_ready = 1'b1;
        repeat (3) step();
        n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
        n_tests++; if (ob_re !== 1'b0)   begin n_fail++; $display("FAIL reset_ob_re: got %0b want 0", ob_re); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
        n_tests++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL reset_m_data: got %h want 0000", m_data); end
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_even();
        clear_mon();
        m_ready = 1'b1;
        fifo_q.push_back(32'hBBBB_AAAA);
        fifo_q.push_back(32'hDDDD_CCCC);
        repeat (2) step();
        exp_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        do_start(16'd4);
        wait_done(60);
        n_tests++; if (got_q.size() != 4) begin n_fail++; $display("FAIL even_count: got %0d elements want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL even_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_tests++; if (re_cnt != 2) begin n_fail++; $display("FAIL even_re_count: got %0d want 2", re_cnt); end
        n_tests++; if (first_re != s_cyc + 2) begin n_fail++; $display("FAIL even_first_re: got cycle %0d want %0d", first_re, s_cyc + 2); end
        n_tests++; if (first_valid != s_cyc + 4) begin n_fail++; $display("FAIL even_first_valid: got cycle %0d want %0d", first_valid, s_cyc + 4); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL even_done_count: got %0d want 1", done_cnt); end
        n_tests++; if (done_cyc != last_hs + 1) begin n_fail++; $display("FAIL even_done_cycle: got %0d want %0d", done_cyc, last_hs + 1); end
        n_tests++; if (last_busy != done_cyc) begin n_fail++; $display("FAIL even_busy_fall: last busy %0d want %0d", last_busy, done_cyc); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL even_busy_end: got %0b want 0", busy); end
    endtask

    task automatic test_odd();
        clear_mon();
        m_ready = 1'b1;
        fifo_q.push_back(32'hBBBB_AAAA);
        fifo_q.push_back(32'hDDDD_CCCC);
        repeat (2) step();
        exp_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        do_start(16'd3);
        wait_done(60);
        n_tests++; if (got_q.size() != 3) begin n_fail++; $display("FAIL odd_count: got %0d elements want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL odd_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_tests++; if (re_cnt != 2) begin n_fail++; $display("FAIL odd_re_count: got %0d want 2", re_cnt); end
        n_tests++; if (fifo_q.size() != 0) begin n_fail++; $display("FAIL odd_fifo_left: got %0d words want 0", fifo_q.size()); end
        n_tests++; if (done_cyc != last_hs + 1) begin n_fail++; $display("FAIL odd_done_cycle: got %0d want %0d", done_cyc, last_hs + 1); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL odd_valid_end: got %0b want 0", m_valid); end
    endtask

    task automatic test_zero();
        clear_mon();
        do_start(16'd0);
        wait_done(10);
        n_tests++; if (done_cyc != s_cyc + 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc, s_cyc + 1); end
        n_tests++; if (re_cnt != 0) begin n_fail++; $display("FAIL zero_re_count: got %0d want 0", re_cnt); end
        n_tests++; if (first_valid != -1) begin n_fail++; $display("FAIL zero_valid: m_valid seen at %0d want never", first_valid); end
        n_tests++; if (first_busy != s_cyc + 1 || last_busy != s_cyc + 1) begin n_fail++; $display("FAIL zero_busy: busy %0d..%0d want %0d..%0d", first_busy, last_busy, s_cyc + 1, s_cyc + 1); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        clear_mon();
        m_ready = 1'b1;
        fifo_q.push_back(32'hBBBB_AAAA);
        fifo_q.push_back(32'hDDDD_CCCC);
        repeat (2) step();
        exp_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        do_start(16'd4);
        while (cyc < s_cyc + 5 && n < 20) begin step(); n++; end
        // During cycle s+5 0xBBBB is on the bus; hold it off for 5 cycles.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== 16'hBBBB) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%0b data=%h want valid=1 data=bbbb", i, m_valid, m_data);
            end
            step();
        end
        m_ready = 1'b1;
        wait_done(60);
        n_tests++; if (got_q.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d elements want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_empty_stall();
        clear_mon();
        m_ready = 1'b1;
        exp_q = '{16'h1111, 16'h2222};
        do_start(16'd2);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                // A second start while busy must be ignored.
                start = 1'b1;
                len   = 16'd8;
            end
            @(negedge clk);
            n_tests++;
            if (ob_re !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall[%0d]: got ob_re=%0b busy=%0b want ob_re=0 busy=1", i, ob_re, busy);
            end
            step();
            start = 1'b0;
        end
        fifo_q.push_back(32'h2222_1111);
        wait_done(60);
        n_tests++; if (got_q.size() != 2) begin n_fail++; $display("FAIL stall_count: got %0d elements want 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_tests++; if (re_cnt != 1) begin n_fail++; $display("FAIL stall_re_count: got %0d want 1", re_cnt); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_mon();
        m_ready = 1'b1;
        fifo_q.push_back(32'h1111_0000);
        fifo_q.push_back(32'h3333_2222);
        fifo_q.push_back(32'h5555_4444);
        fifo_q.push_back(32'h7777_6666);
        repeat (2) step();
        do_start(16'd8);
        while (dbg_state !== ST_EMIT_HI && n < 30) begin @(negedge clk); n++; end
        n_tests++;
        if (dbg_state !== ST_EMIT_HI) begin n_fail++; $display("FAIL rmid_reach: state %0d want %0d", dbg_state, ST_EMIT_HI); end
        // Assert reset between clock edges: outputs must clear without an edge.
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %0b want 0", m_valid); end
        n_tests++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL rmid_data: got %h want 0000", m_data); end
        n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rmid_busy: got %0b want 0", busy); end
        n_tests++; if (dbg_state !== 3'd0 || dbg_rem !== '0 || dbg_hold !== '0) begin
            n_fail++; $display("FAIL rmid_regs: got state=%0d rem=%0d hold=%h want 0/0/0", dbg_state, dbg_rem, dbg_hold);
        end
        step();
        rst_n = 1'b1;
        repeat (2) step();
        clear_mon();
        exp_q = '{16'h2222, 16'h3333};
        do_start(16'd2);
        wait_done(60);
        n_tests++; if (got_q.size() != 2) begin n_fail++; $display("FAIL rmid_count: got %0d elements want 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        fifo_q.delete();
    endtask

    // ---------------- sequence ----------------
    initial begin
        clear_mon();
        test_reset();
        test_even();
        test_odd();
        test_zero();
        test_backpressure();
        test_empty_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
